// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle sequencer and the control unit:
// state encoding, opcode constants and instruction-length classification.
package cpu_pkg;

  // State codes seen by the control unit.
  typedef enum logic [3:0] {
    HALT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC1  = 4'd3,
    EXEC2  = 4'd4
  } state_t;

  // Number of execute cycles an opcode needs, or unsupported.
  typedef enum logic [1:0] {
    ONE_EXEC = 2'd0,
    TWO_EXEC = 2'd1,
    ILLEGAL  = 2'd2
  } opclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  function automatic opclass_t classify_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_JAL: return TWO_EXEC;
      OP_BEQ, OP_J:                   return ONE_EXEC;
      default:                        return ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/cpu_state_sequencer_stall_timer.sv
// Counts consecutive stalled cycles and flags the cycle in which the
// stall has lasted WAIT_LIMIT cycles. WAIT_LIMIT=0 removes the counter.
module stall_timer #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stalled,
  output logic expire
);

  generate
    if (WAIT_LIMIT > 0) begin : g_timer
      localparam int W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

      logic [W-1:0] wait_cnt_reg;

      // Expire on the WAIT_LIMIT-th consecutive stalled cycle.
      assign expire = stalled && (wait_cnt_reg == W'(WAIT_LIMIT - 1));

      // Count stalled cycles; any free-running cycle or an expiry restarts it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wait_cnt_reg <= '0;
        end else if (!stalled || expire) begin
          wait_cnt_reg <= '0;
        end else begin
          wait_cnt_reg <= wait_cnt_reg + W'(1);
        end
      end
    end else begin : g_no_timer
      logic unused_inputs;
      assign unused_inputs = clk ^ rst_n ^ stalled;
      assign expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/cpu_state_sequencer.sv
// Multicycle instruction sequencer: HALT -> FETCH -> DECODE -> EXEC1 [-> EXEC2],
// with memory-wait stalls, PC commit strobe, sticky error flags and counters.
module cpu_state_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int WAIT_LIMIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic             mem_waitrequest,
  input  logic             pc_next_zero,
  output logic [3:0]       state,
  output logic             active,
  output logic             pc_write,
  output logic             stall,
  output logic             illegal_op,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  state_t           state_reg, state_next;
  opclass_t         cls_reg;
  logic             is_lw_reg, is_sw_reg;
  logic             active_reg, illegal_reg, timeout_reg;
  logic [CNT_W-1:0] instr_reg, cycle_reg;
  logic             stall_int, commit, expire, set_illegal;

  stall_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_stall_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .stalled(stall_int),
    .expire (expire)
  );

  // A memory access is held only in FETCH, in EXEC1 of lw and in EXEC2 of sw.
  always_comb begin
    stall_int = 1'b0;
    case (state_reg)
      FETCH:   stall_int = mem_waitrequest;
      EXEC1:   stall_int = is_lw_reg & mem_waitrequest;
      EXEC2:   stall_int = is_sw_reg & mem_waitrequest;
      default: stall_int = 1'b0;
    endcase
  end

  // Commit happens in the last, unstalled execute cycle.
  always_comb begin
    commit = !stall_int &&
             (((state_reg == EXEC1) && (cls_reg == ONE_EXEC)) || (state_reg == EXEC2));
  end

  // Next-state selection; expiry and illegal decode both abort to HALT.
  always_comb begin
    state_next  = state_reg;
    set_illegal = 1'b0;
    case (state_reg)
      HALT: if (start) state_next = FETCH;
      FETCH: begin
        if (expire)          state_next = HALT;
        else if (!stall_int) state_next = DECODE;
      end
      DECODE: begin
        if (classify_op(opcode) == ILLEGAL) begin
          state_next  = HALT;
          set_illegal = 1'b1;
        end else begin
          state_next = EXEC1;
        end
      end
      EXEC1, EXEC2: begin
        if (expire)          state_next = HALT;
        else if (commit)     state_next = pc_next_zero ? HALT : FETCH;
        else if (!stall_int) state_next = EXEC2;
      end
      default: state_next = HALT;
    endcase
  end

  // Latch the instruction class at DECODE so later opcode changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_reg   <= ONE_EXEC;
      is_lw_reg <= 1'b0;
      is_sw_reg <= 1'b0;
    end else if (state_reg == DECODE) begin
      cls_reg   <= classify_op(opcode);
      is_lw_reg <= (opcode == OP_LW);
      is_sw_reg <= (opcode == OP_SW);
    end
  end

  // State register, registered active flag and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= HALT;
      active_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      active_reg <= (state_next != HALT);
      if (set_illegal) illegal_reg <= 1'b1;
      if (expire)      timeout_reg <= 1'b1;
    end
  end

  // Retired-instruction and active-cycle counters, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg <= '0;
      cycle_reg <= '0;
    end else begin
      if (commit)             instr_reg <= instr_reg + CNT_W'(1);
      if (state_reg != HALT)  cycle_reg <= cycle_reg + CNT_W'(1);
    end
  end

  assign state       = state_reg;
  assign active      = active_reg;
  assign stall       = stall_int;
  assign pc_write    = commit;
  assign illegal_op  = illegal_reg;
  assign timeout     = timeout_reg;
  assign instr_count = instr_reg;
  assign cycle_count = cycle_reg;

endmodule

// File: doc/cpu_state_sequencer.md
Name: cpu_state_sequencer

Overview:
- Multicycle sequencer that generates the 4-bit `state` code consumed by the control unit: HALT=0, FETCH=1, DECODE=2, EXEC1=3, EXEC2=4.
- Sits directly upstream of the control unit and shares the `opcode` bus with it.
- Tracks the instruction length for each opcode and stalls on memory waitrequest.
- Commits the PC update, halts on a jump to address 0, and keeps retired-instruction and cycle counters.

Parameters:
- CNT_W, 32, width of the instr_count and cycle_count counters.
- WAIT_LIMIT, 0, maximum consecutive stall cycles before a timeout halt; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that leaves HALT and begins fetching.
- opcode  in  6  instruction[31:26] from the instruction register; valid from DECODE onward.
- mem_waitrequest  in  1  memory is not ready; the current memory access must be held.
- pc_next_zero  in  1  the next-PC value computed this cycle equals 0x00000000.
- state  out  4  current state code, driven to the control unit.
- active  out  1  high whenever state != HALT.
- pc_write  out  1  one-cycle PC update strobe at instruction commit.
- stall  out  1  the current cycle is held by mem_waitrequest.
- illegal_op  out  1  sticky; set when an unsupported opcode is decoded.
- timeout  out  1  sticky; set when the stall limit is exceeded.
- instr_count  out  CNT_W  number of retired instructions.
- cycle_count  out  CNT_W  number of cycles with active=1.

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0 the outputs are: state=HALT, active=0, pc_write=0, stall=0, illegal_op=0, timeout=0, both counters=0, internal wait counter=0.
- Reset asserted mid-instruction aborts that instruction immediately. No pc_write is issued.
- HALT: remains in HALT until start=1 is sampled, then goes to FETCH. start is ignored in every other state.
- FETCH: memory access. If mem_waitrequest=1, hold FETCH with stall=1; otherwise go to DECODE.
- DECODE: always exactly one cycle. opcode is classified here:
  - 000000 (R-type), 100011 (lw), 101011 (sw), 000011 (jal) are two-execute instructions.
  - 000100 (beq), 000010 (j) are one-execute instructions.
  - Any other opcode: set illegal_op and go to HALT; no pc_write is issued.
  - Legal opcodes go to EXEC1.
- The opcode class is latched at DECODE. An opcode change during EXEC1/EXEC2 has no effect on sequencing.
- EXEC1:
  - lw is a memory read here; it holds EXEC1 with stall=1 while mem_waitrequest=1.
  - One-execute instructions commit at the end of this state.
  - Two-execute instructions go to EXEC2.
- EXEC2:
  - sw is a memory write here; it holds EXEC2 with stall=1 while mem_waitrequest=1.
  - All instructions that reach EXEC2 commit at the end of this state.
- mem_waitrequest is ignored in DECODE, in EXEC1 for any opcode other than lw, and in EXEC2 for any opcode other than sw.
- Commit cycle (the last execute cycle, not stalled):
  - pc_write=1 for exactly that cycle.
  - instr_count increments on the following edge.
  - Next state is HALT if pc_next_zero=1, otherwise FETCH.
- Counter arithmetic:
  - cycle_count increments on every edge where state != HALT.
  - Both counters wrap modulo 2^CNT_W.
  - Both counters clear only on reset; they are preserved across HALT/start.
- Stall timeout (WAIT_LIMIT>0):
  - The wait counter counts consecutive stalled cycles and clears on any non-stalled cycle.
  - When the count reaches WAIT_LIMIT while still stalled, set timeout and go to HALT; no pc_write is issued.
- Simultaneous commit with pc_next_zero=1: the commit is honoured (pc_write=1, instr_count increments) and then the sequencer halts.
- illegal_op and timeout clear only on reset.
- Latency:
  - One-execute instruction: 3 cycles plus stalls.
  - Two-execute instruction: 4 cycles plus stalls.
- All outputs are registered except stall and pc_write. These two are combinational from the state, the latched opcode class, mem_waitrequest and the wait counter.

Decomposition:
- Shared package cpu_pkg holds:
  - state_t enum, 4 bits: HALT=0, FETCH=1, DECODE=2, EXEC1=3, EXEC2=4.
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL.
  - A function classifying an opcode as {ONE_EXEC, TWO_EXEC, ILLEGAL}.
- The control unit imports the same package.
- One sub-module is natural: stall_timer, holding the wait counter and the WAIT_LIMIT compare.

Test Plan:
- Reset release, then start pulse, then R-type (000000) with waitrequest=0 → state sequence 0,1,2,3,4,1; pc_write high only in the EXEC2 cycle; instr_count=1.
- lw with mem_waitrequest=1 for 3 cycles during EXEC1 → state holds at 3 for 4 cycles with stall=1 for 3 of them; commit in EXEC2; cycle_count=7.
- beq then j → each instruction runs 1,2,3 then back to 1; pc_write in EXEC1; instr_count=2 after 6 cycles.
- jal committing with pc_next_zero=1 → pc_write=1 in EXEC2, next state=0, active=0; counters held; a later start resumes with instr_count unchanged.
- opcode 111111 at DECODE → illegal_op=1, next state=0, no pc_write; opcode changed during EXEC1 of a legal op → sequencing unaffected.
- WAIT_LIMIT=4 with waitrequest held high in FETCH → timeout=1 and state=0 after 4 stalled cycles; rst_n pulsed low asynchronously mid-EXEC1 → all outputs cleared immediately.
